fetch_stage: RTL
================

# fetch_stage

Instruction-fetch stage and IF/ID pipeline register for the 5-stage MIPS pipeline. It owns the PC, issues in-order requests to a variable-latency instruction memory, buffers returned words in a small prefetch queue, and presents one instruction per cycle to decode. It sits directly upstream of the hazard unit: it consumes `StallD` from it and the decode-stage branch redirect (`PCSrcD`/`PCBranchD`), and its `InstrD` feeds the register-address fields the hazard unit compares.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000: first fetch address after reset.
- `DEPTH`, 2: prefetch queue entries (power of two, ≥2); also bounds outstanding requests.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `StallD` in 1: hold IF/ID and queue head (hazard unit stall).
- `PCSrcD` in 1: branch taken in decode.
- `PCBranchD` in 32: redirect target.
- `imem_req` out 1: fetch request valid.
- `imem_addr` out 32: fetch address (= `pcF`).
- `imem_gnt` in 1: request accepted this cycle.
- `imem_rvalid` in 1: response valid; responses in order, one per grant, ≥1 cycle after grant.
- `imem_rdata` in 32: instruction word.
- `InstrD` out 32: decode instruction; 0 (sll nop) when invalid.
- `PCPlus4D` out 32: PC+4 of `InstrD`.
- `ValidD` out 1: `InstrD` is a real instruction.
- `stall_cnt`, `bubble_cnt` out 32 each: only with `FETCH_PERF_EN`.

## Operation
- State: `pcF`; `outstanding` (0..DEPTH); `discard` (0..DEPTH); queue of {instr, pc}; a PC-tag FIFO written at grant and read at response.
- Redirect this cycle: `redir = PCSrcD & ~StallD`. `PCSrcD` while `StallD`=1 is ignored.
- Request: `imem_req = ~rst & ~redir & (outstanding + occupancy < DEPTH)`. On `imem_req & imem_gnt`: push tag `pcF`, `pcF <= pcF+4`, `outstanding++`.
- Response: on `imem_rvalid`, `outstanding--`, pop tag. If `discard>0`, drop the word and `discard--`; otherwise deliver.
- IF/ID update when `~StallD`:
  - queue non-empty: load head, pop;
  - queue empty and a delivered response this cycle: bypass it straight into IF/ID;
  - else load bubble (`ValidD=0`, `InstrD=0`, `PCPlus4D` unchanged).
- Undelivered responses push into the queue. The request rule guarantees no overflow.
- When `StallD`=1, IF/ID holds and deliveries push to the queue.
- On `redir`:
  - `pcF <= PCBranchD`; queue cleared.
  - `discard <= outstanding` minus any response arriving this cycle; that response is dropped.
  - IF/ID loads a bubble. No request is issued that cycle.
- Same-cycle grant and response: counters net to zero change.

## Timing
- Reset values: `pcF=RESET_PC`, `imem_addr=RESET_PC`, `imem_req=0` while `rst`, `ValidD=0`, `InstrD=0`, `PCPlus4D=0`, queue empty, `outstanding=discard=0`, counters 0.
- `rst` mid-operation clears all state. The instruction memory shares `rst`, and no pre-reset responses arrive afterwards.
- First `imem_req` in the first cycle with `rst`=0.
- With 1-cycle memory and grants every cycle:
  - grant at cycle n gives `ValidD`=1 after edge n+1 (bypass);
  - sustained 1 instruction/cycle.
- Redirect penalty: the target is requested in cycle r+1. With 1-cycle memory it is valid in ID after edge r+2. The edge ending cycle r loads a bubble.
- `imem_addr` and `imem_req` depend combinationally only on state, `PCSrcD` and `StallD`.

## Configuration
- `FETCH_PERF_EN` defined:
  - `stall_cnt` counts cycles with `StallD`=1;
  - `bubble_cnt` counts IF/ID bubble loads caused by an empty queue, not by redirect;
  - both saturate at 32'hFFFF_FFFF and clear on `rst`.
- Not defined: both ports and their logic are absent. Behaviour is otherwise identical.

## Test plan
- Reset release, 1-cycle memory, grant always: `imem_addr` goes 0,4,8…. `ValidD`=1 from the edge after the first response, with `PCPlus4D`=4,8,12 on consecutive cycles.
- `StallD`=1 for 3 cycles mid-stream: `InstrD` holds. Queue fills to `DEPTH` and `imem_req` drops. On release the next instructions follow with no gap and none lost.
- 3-cycle memory latency, `DEPTH`=2: at most 2 outstanding. Each starved cycle loads a bubble, and `bubble_cnt` increments when `FETCH_PERF_EN` is defined.
- `PCSrcD`=1, `PCBranchD`=32'h100 with 2 requests outstanding: both late responses are dropped. Next valid `PCPlus4D`=32'h104, and no `imem_req` occurs in the redirect cycle.
- `PCSrcD`=1 with `StallD`=1: no redirect. Redirect takes effect the cycle `StallD` falls.
- `rst` asserted mid-burst: outputs return to reset values next edge, and fetch restarts at `RESET_PC`.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction fetch stage with prefetch queue and IF/ID register for the 5-stage MIPS pipeline.
// Optional FETCH_PERF_EN adds saturating stall/bubble counters.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        StallD,
  input  logic        PCSrcD,
  input  logic [31:0] PCBranchD,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] InstrD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] stall_cnt,
  output logic [31:0] bubble_cnt
`endif
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  logic [31:0]   pc_f;
  logic [CW-1:0] outstanding, discard, q_cnt;
  logic [PW-1:0] q_rd, q_wr, t_rd, t_wr;
  logic [31:0]   q_instr [DEPTH];
  logic [31:0]   q_pc    [DEPTH];
  logic [31:0]   tag_pc  [DEPTH];

  logic          redir, grant, deliver, q_empty;
  logic          pop_q, push_q, bypass, starve;
  logic [CW:0]   inflight;
  logic [31:0]   resp_pc;

  always_comb begin
    redir     = PCSrcD & ~StallD;
    inflight  = {1'b0, outstanding} + {1'b0, q_cnt};
    imem_req  = ~rst & ~redir & (inflight < (CW+1)'(DEPTH));
    imem_addr = pc_f;
    grant     = imem_req & imem_gnt;
    // A response arriving in the redirect cycle belongs to the old path.
    deliver   = imem_rvalid & (discard == '0) & ~redir;
    q_empty   = (q_cnt == '0);
    pop_q     = ~StallD & ~redir & ~q_empty;
    bypass    = ~StallD & ~redir & q_empty & deliver;
    starve    = ~StallD & ~redir & q_empty & ~deliver;
    push_q    = deliver & ~bypass;
    resp_pc   = tag_pc[t_rd];
  end

  // Payload storage needs no reset; occupancy is tracked by the counters below.
  always_ff @(posedge clk) begin
    if (!rst && grant)
      tag_pc[t_wr] <= pc_f;
    if (!rst && !redir && push_q) begin
      q_instr[q_wr] <= imem_rdata;
      q_pc[q_wr]    <= resp_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_f        <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
      t_rd        <= '0;
      t_wr        <= '0;
      q_rd        <= '0;
      q_wr        <= '0;
      q_cnt       <= '0;
      ValidD      <= 1'b0;
      InstrD      <= '0;
      PCPlus4D    <= '0;
    end else begin
      if (grant)
        t_wr <= t_wr + PW'(1);
      if (imem_rvalid)
        t_rd <= t_rd + PW'(1);
      outstanding <= outstanding + CW'(grant) - CW'(imem_rvalid);

      if (redir)
        pc_f <= PCBranchD;
      else if (grant)
        pc_f <= pc_f + 32'd4;

      if (redir)
        discard <= outstanding - CW'(imem_rvalid);
      else if (imem_rvalid && discard != '0)
        discard <= discard - CW'(1);

      if (redir) begin
        q_rd  <= '0;
        q_wr  <= '0;
        q_cnt <= '0;
      end else begin
        if (push_q)
          q_wr <= q_wr + PW'(1);
        if (pop_q)
          q_rd <= q_rd + PW'(1);
        q_cnt <= q_cnt + CW'(push_q) - CW'(pop_q);
      end

      if (redir || starve) begin
        ValidD <= 1'b0;
        InstrD <= '0;
      end else if (pop_q) begin
        ValidD   <= 1'b1;
        InstrD   <= q_instr[q_rd];
        PCPlus4D <= q_pc[q_rd] + 32'd4;
      end else if (bypass) begin
        ValidD   <= 1'b1;
        InstrD   <= imem_rdata;
        PCPlus4D <= resp_pc + 32'd4;
      end
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (StallD && stall_cnt != 32'hFFFF_FFFF)
        stall_cnt <= stall_cnt + 32'd1;
      if (starve && bubble_cnt != 32'hFFFF_FFFF)
        bubble_cnt <= bubble_cnt + 32'd1;
    end
  end
`endif

endmodule
